// File: rtl/conv_seq_ctrl.sv
// Tap/cycle sequencer for the conv MAC path: issues 8 tap beats per output cycle, then drains and pulses done.
// Latency: first beat one clock after start is accepted; done DRAIN+1 clocks after the last beat.
// Backpressure: stall freezes beat issue (en low, tap/cyc hold); the out_valid delay line keeps shifting.
module conv_seq_ctrl #(
  parameter int TAP_W = 3,
  parameter int CYC_W = 9,
  parameter int DRAIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CYC_W-1:0] num_cycles,
  input  logic             stall,
  output logic             busy,
  output logic             en,
  output logic [TAP_W-1:0] tap,
  output logic [CYC_W-1:0] cyc,
  output logic             first_tap,
  output logic             last_tap,
  output logic             out_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [TAP_W-1:0] TAP_LAST   = '1;
  localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN - 1);

  state_t             state;
  logic [CYC_W-1:0]   count;
  logic [3:0]         drain_cnt;
  logic [DRAIN-1:0]   ov_pipe;
  logic               final_beat;

  // Beat strobes follow stall in the same cycle so a stalled beat is never counted by the MAC.
  assign en         = (state == S_RUN) && !stall;
  assign first_tap  = en && (tap == '0);
  assign last_tap   = en && (tap == TAP_LAST);
  // count is at least 1 whenever RUN is entered, so count-1 cannot underflow here.
  assign final_beat = last_tap && (cyc == count - CYC_W'(1));
  assign out_valid  = ov_pipe[DRAIN-1];

  // Sequencer FSM: latches the layer length, steps tap/cyc per beat, counts the drain, pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tap       <= '0;
      cyc       <= '0;
      count     <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count <= num_cycles;
            tap   <= '0;
            cyc   <= '0;
            busy  <= 1'b1;
            if (num_cycles == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (final_beat) begin
              // tap/cyc hold the final beat's indices through drain and done
              state     <= S_DRAIN;
              drain_cnt <= '0;
            end else begin
              tap <= tap + TAP_W'(1);
              if (tap == TAP_LAST) cyc <= cyc + CYC_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          tap   <= '0;
          cyc   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // out_valid is last_tap delayed exactly DRAIN clocks, matching the MAC pipeline depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      ov_pipe <= '0;
    end else begin
      ov_pipe[0] <= last_tap;
      for (int i = 1; i < DRAIN; i++) ov_pipe[i] <= ov_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: table of layer runs plus hand sequences for held start and mid-run reset.
// Inputs are driven 1ns after the rising edge; outputs are sampled 2ns after it.
// Expected beat indices, done cycle and out_valid counts are computed from the layer length and stall pattern.
module tb_conv_seq_ctrl;

  localparam int TAP_W = 3;
  localparam int CYC_W = 9;
  localparam int DRAIN = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CYC_W-1:0] num_cycles;
  logic             stall;
  logic             busy, en, first_tap, last_tap, out_valid, done;
  logic [TAP_W-1:0] tap;
  logic [CYC_W-1:0] cyc;

  int checks = 0;
  int errors = 0;

  conv_seq_ctrl #(.TAP_W(TAP_W), .CYC_W(CYC_W), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .start(start), .num_cycles(num_cycles), .stall(stall),
    .busy(busy), .en(en), .tap(tap), .cyc(cyc), .first_tap(first_tap),
    .last_tap(last_tap), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n;          // num_cycles
    int stall_at;   // beats issued before the stall begins
    int stall_len;  // stalled cycles
    int poke_k;     // cycle (after accept) to pulse a spurious start, 0 = none
    int exp_beats;
    int exp_done;   // cycle index of done, counting the first cycle after accept as 1
    int exp_ov;
    int exp_last_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int beats, stalls, ovs, dones, done_k, last_cyc;
    bit lt_d1, lt_d2;
    beats = 0; stalls = 0; ovs = 0; dones = 0; done_k = 0; last_cyc = 0;
    lt_d1 = 0; lt_d2 = 0;
    start = 1'b1;
    num_cycles = CYC_W'(v.n);
    for (int k = 1; k <= 8 * v.n + v.stall_len + DRAIN + 10 && done_k == 0; k++) begin
      tick();
      start      = (k == v.poke_k);
      num_cycles = (k == v.poke_k) ? 9'd5 : 9'd7;
      stall      = (stalls < v.stall_len) && (beats == v.stall_at);
      #1;
      chk("busy_active", busy, 1);
      if (stall) begin
        chk("en_stalled", en, 0);
        chk("last_tap_stalled", last_tap, 0);
        stalls++;
      end
      if (en) begin
        chk("tap", tap, beats % 8);
        chk("cyc", cyc, beats / 8);
        chk("first_tap", first_tap, (beats % 8) == 0);
        chk("last_tap", last_tap, (beats % 8) == 7);
        last_cyc = cyc;
        beats++;
      end
      chk("out_valid_delay", out_valid, lt_d2);
      lt_d2 = lt_d1;
      lt_d1 = last_tap;
      ovs += out_valid;
      if (done) done_k = k;
    end
    stall = 1'b0;
    start = 1'b0;
    chk("beat_count", beats, v.exp_beats);
    chk("done_cycle", done_k, v.exp_done);
    chk("out_valid_count", ovs, v.exp_ov);
    if (v.exp_beats > 0) chk("last_cyc", last_cyc, v.exp_last_cyc);
    tick();
    #1;
    chk("busy_after_done", busy, 0);
    chk("done_single_pulse", done, 0);
    chk("en_idle", en, 0);
    chk("tap_idle", tap, 0);
    chk("cyc_idle", cyc, 0);
  endtask

  // Hard stop in case something upstream of the bounded loops goes wrong.
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats, ovs, dones, busys, done_k;
    vecs[0] = '{1,   0, 0, 0, 8,    11,   1,   0};
    vecs[1] = '{3,   4, 3, 0, 24,   30,   3,   2};
    vecs[2] = '{0,   0, 0, 0, 0,    1,    0,   0};
    vecs[3] = '{2,   0, 0, 5, 16,   19,   2,   1};
    vecs[4] = '{1,   7, 2, 0, 8,    13,   1,   0};
    vecs[5] = '{511, 0, 0, 0, 4088, 4091, 511, 510};

    reset = 1'b1; start = 1'b0; stall = 1'b0; num_cycles = '0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", en, 0);
    chk("rst_tap", tap, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_first_tap", first_tap, 0);
    chk("rst_last_tap", last_tap, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start held high: the IDLE cycle after DONE accepts the next layer
    start = 1'b1; num_cycles = 9'd1;
    done_k = 0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      tick();
      #1;
      if (done) done_k = k;
    end
    chk("held_first_done", done_k, 11);
    tick(); #1;
    chk("held_idle_busy", busy, 0);
    chk("held_idle_en", en, 0);
    tick(); #1;
    chk("held_restart_en", en, 1);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_tap", tap, 0);
    chk("held_restart_first", first_tap, 1);
    start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 20 && done_k == 0; k++) begin
      if (done) done_k = k;
      if (done_k == 0) begin
        tick(); #1;
      end
    end
    chk("held_second_done", done_k, 11);
    tick(); #1;

    // reset in mid-run, once with out_valid already out and once with it still in flight
    for (int r = 0; r < 2; r++) begin
      int stop_at;
      stop_at = (r == 0) ? 10 : 16;
      beats = 0;
      start = 1'b1; num_cycles = 9'd4;
      for (int k = 1; k <= 40 && beats < stop_at; k++) begin
        tick();
        start = 1'b0;
        #1;
        if (en) beats++;
      end
      chk("rst_mid_beats", beats, stop_at);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_en", en, 0);
      chk("mid_rst_tap", tap, 0);
      chk("mid_rst_cyc", cyc, 0);
      chk("mid_rst_last_tap", last_tap, 0);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_done", done, 0);
      ovs = 0; dones = 0; busys = 0;
      for (int k = 0; k < 20; k++) begin
        tick(); #1;
        ovs += out_valid;
        dones += done;
        busys += busy;
      end
      chk("post_rst_out_valid", ovs, 0);
      chk("post_rst_done", dones, 0);
      chk("post_rst_busy", busys, 0);
    end

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
